// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: D = A - B - BIN over WIDTH bits, DIGIT bits per clock.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output 'ovf'.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Illegal WIDTH/DIGIT combinations must stop elaboration.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("serial_subtractor: WIDTH must be at least 1");
    end else if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $error("serial_subtractor: DIGIT must be in 1..WIDTH");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_k;
  logic [DIGIT-1:0] b_k;
  logic [DIGIT-1:0] diff;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last;

  assign a_k = a_sh[DIGIT-1:0];
  assign b_k = b_sh[DIGIT-1:0];

  // The extra top bit of a (DIGIT+1)-bit subtraction is exactly a_k < b_k + br.
  assign {br_next, diff} = {1'b0, a_k} - {1'b0, b_k} - {{DIGIT{1'b0}}, br};

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // New digits enter at the top, so after N steps digit 0 sits at the LSB end.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign res_next = diff;
    end else begin : g_multi
      assign res_next = {diff, res[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            res   <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh >> DIGIT;
          br   <= br_next;
          res  <= res_next;
          cnt  <= cnt + CW'(1);
          if (last) begin
            d      <= res_next;
            borrow <= br_next;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits are kept because the shift registers lose them during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if ((state == IDLE || state == DONE) && start) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      if (state == RUN && last) begin
        ovf <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
      end
    end
  end
`endif

endmodule
